// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: three write-back sources, link cycles
// and a pending-load scoreboard, with a fixed one-cycle issue latency.
module rf_wb_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s0_valid,
  input  logic                      s1_valid,
  input  logic                      s2_valid,
  output logic                      s0_ready,
  output logic                      s1_ready,
  output logic                      s2_ready,
  input  logic [ADDR_SIZE-1:0]      s0_wa,
  input  logic [ADDR_SIZE-1:0]      s1_wa,
  input  logic [ADDR_SIZE-1:0]      s2_wa,
  input  logic [WIDTH-1:0]          s0_din,
  input  logic [WIDTH-1:0]          s1_din,
  input  logic [WIDTH-1:0]          s2_din,
  input  logic                      lnk_req,
  output logic                      lnk_ready,
  input  logic                      sb_set,
  input  logic [ADDR_SIZE-1:0]      sb_addr,
  output logic                      rf_wen,
  output logic [ADDR_SIZE-1:0]      rf_wa,
  output logic [WIDTH-1:0]          rf_din,
  output logic                      rf_link,
  output logic                      pc_wr,
  output logic [(1<<ADDR_SIZE)-1:0] pend,
  output logic [1:0]                rr_ptr
);

  localparam int NREG = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] PC_REG  = '1;
  localparam logic [ADDR_SIZE-1:0] LNK_REG =
    ADDR_SIZE'(NREG - 2);

  logic [2:0]           valid;
  logic [2:0]           gnt;
  logic                 xfer;
  logic [1:0]           sel_id;
  logic [1:0]           rr_nxt;
  logic [ADDR_SIZE-1:0] sel_wa;
  logic [WIDTH-1:0]     sel_din;
  logic [NREG-1:0]      set_m;
  logic [NREG-1:0]      clr_m;

  assign valid = {s2_valid, s1_valid, s0_valid};

  // Link cycles pre-empt data so a link never lands alongside a write.
  assign lnk_ready = reset & lnk_req;

  always_comb begin
    gnt = '0;
    if (reset && !lnk_req) begin
      case (rr_ptr)
        2'd1: begin
          if (valid[1])      gnt = 3'b010;
          else if (valid[2]) gnt = 3'b100;
          else if (valid[0]) gnt = 3'b001;
        end
        2'd2: begin
          if (valid[2])      gnt = 3'b100;
          else if (valid[0]) gnt = 3'b001;
          else if (valid[1]) gnt = 3'b010;
        end
        default: begin
          if (valid[0])      gnt = 3'b001;
          else if (valid[1]) gnt = 3'b010;
          else if (valid[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  assign s0_ready = gnt[0];
  assign s1_ready = gnt[1];
  assign s2_ready = gnt[2];
  assign xfer     = |gnt;

  always_comb begin
    sel_id  = 2'd0;
    sel_wa  = s0_wa;
    sel_din = s0_din;
    unique case (1'b1)
      gnt[1]: begin
        sel_id  = 2'd1;
        sel_wa  = s1_wa;
        sel_din = s1_din;
      end
      gnt[2]: begin
        sel_id  = 2'd2;
        sel_wa  = s2_wa;
        sel_din = s2_din;
      end
      default: ;
    endcase
  end

  assign rr_nxt = (sel_id == 2'd2) ? 2'd0 : sel_id + 2'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_wen  <= 1'b0;
      rf_link <= 1'b0;
      rf_wa   <= '0;
      rf_din  <= '0;
      pc_wr   <= 1'b0;
      rr_ptr  <= 2'd0;
    end else begin
      rf_wen  <= xfer;
      rf_link <= lnk_ready;
      pc_wr   <= xfer && (sel_wa == PC_REG);
      if (xfer) begin
        rf_wa  <= sel_wa;
        rf_din <= sel_din;
        rr_ptr <= rr_nxt;
      end
    end
  end

  // Clears follow the issued write; a fresh set wins over a clear.
  assign set_m = sb_set ? (NREG'(1) << sb_addr) : '0;
  assign clr_m =
    (rf_wen  ? (NREG'(1) << rf_wa)   : '0) |
    (rf_link ? (NREG'(1) << LNK_REG) : '0);

  always_ff @(posedge clk) begin
    if (!reset) pend <= '0;
    else        pend <= (pend & ~clr_m) | set_m;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int W = 32;
  localparam int A = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         s0_valid, s1_valid, s2_valid;
  logic         s0_ready, s1_ready, s2_ready;
  logic [A-1:0] s0_wa, s1_wa, s2_wa;
  logic [W-1:0] s0_din, s1_din, s2_din;
  logic         lnk_req, lnk_ready;
  logic         sb_set;
  logic [A-1:0] sb_addr;
  logic         rf_wen, rf_link, pc_wr;
  logic [A-1:0] rf_wa;
  logic [W-1:0] rf_din;
  logic [N-1:0] pend;
  logic [1:0]   rr_ptr;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.WIDTH(W), .ADDR_SIZE(A)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s1_valid(s1_valid), .s2_valid(s2_valid),
    .s0_ready(s0_ready), .s1_ready(s1_ready), .s2_ready(s2_ready),
    .s0_wa(s0_wa), .s1_wa(s1_wa), .s2_wa(s2_wa),
    .s0_din(s0_din), .s1_din(s1_din), .s2_din(s2_din),
    .lnk_req(lnk_req), .lnk_ready(lnk_ready),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_din(rf_din),
    .rf_link(rf_link), .pc_wr(pc_wr),
    .pend(pend), .rr_ptr(rr_ptr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Expected grant: first valid source in rotating order from rr.
  function automatic logic [2:0] exp_gnt(logic rst, logic lnk,
                                         logic [2:0] v, int rr);
    if (!rst || lnk) return 3'b000;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (rr + i) % 3;
      if (v[k]) return 3'b001 << k;
    end
    return 3'b000;
  endfunction

  function automatic logic [A-1:0] src_wa(int k);
    case (k)
      0:       return s0_wa;
      1:       return s1_wa;
      default: return s2_wa;
    endcase
  endfunction

  function automatic logic [W-1:0] src_din(int k);
    case (k)
      0:       return s0_din;
      1:       return s1_din;
      default: return s2_din;
    endcase
  endfunction

  // Behavioural model state.
  int           m_rr;
  logic         m_wen, m_link;
  logic [A-1:0] m_wa;
  logic [W-1:0] m_din;
  logic [N-1:0] m_pend;
  logic [2:0]   m_last;
  bit           mvalid = 1'b0;

  always @(posedge clk) begin
    logic [2:0]   g;
    logic [N-1:0] p;
    g = exp_gnt(reset, lnk_req,
                {s2_valid, s1_valid, s0_valid}, m_rr);
    p = m_pend;
    if (!reset) begin
      m_rr   <= 0;
      m_wen  <= 1'b0;
      m_link <= 1'b0;
      m_wa   <= '0;
      m_din  <= '0;
      m_pend <= '0;
      m_last <= '0;
      mvalid <= 1'b1;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (sb_set && int'(sb_addr) == r)
          p[r] = 1'b1;
        else if ((m_wen && int'(m_wa) == r) ||
                 (m_link && r == N - 2))
          p[r] = 1'b0;
      end
      m_pend <= p;
      m_last <= g;
      m_link <= lnk_req;
      m_wen  <= (g != 3'b000);
      for (int k = 0; k < 3; k++) begin
        if (g[k]) begin
          m_wa  <= src_wa(k);
          m_din <= src_din(k);
          m_rr  <= (k + 1) % 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (mvalid) begin
      e = exp_gnt(reset, lnk_req,
                  {s2_valid, s1_valid, s0_valid}, m_rr);
      chk("s0_ready", s0_ready, e[0]);
      chk("s1_ready", s1_ready, e[1]);
      chk("s2_ready", s2_ready, e[2]);
      chk("lnk_ready", lnk_ready, reset && lnk_req);
      chk("rf_wen", rf_wen, m_wen);
      chk("rf_link", rf_link, m_link);
      chk("rf_wa", rf_wa, m_wa);
      chk("rf_din", rf_din, m_din);
      chk("pc_wr", pc_wr, m_wen && m_wa == 4'hF);
      chk("pend", pend, m_pend);
      chk("rr_ptr", rr_ptr, m_rr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [A-1:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 4'd6;
      1:       return 4'd14;
      2:       return 4'd15;
      default: return A'($urandom_range(0, N - 1));
    endcase
  endfunction

  task automatic new_req(output logic v, output logic [A-1:0] a,
                         output logic [W-1:0] d);
    v = ($urandom_range(0, 2) != 0);
    a = rand_addr();
    d = $urandom;
  endtask

  initial begin
    reset    = 1'b0;
    lnk_req  = 1'b0;
    sb_set   = 1'b0;
    sb_addr  = '0;
    s0_valid = 1'b1; s0_wa = 4'd3; s0_din = 32'h11;
    s1_valid = 1'b1; s1_wa = 4'd4; s1_din = 32'h22;
    s2_valid = 1'b1; s2_wa = 4'd5; s2_din = 32'h33;

    repeat (2) begin
      @(negedge clk);
      chk("d_rst_ready",
          {s2_ready, s1_ready, s0_ready}, 3'b000);
      chk("d_rst_wen", rf_wen, 1'b0);
      chk("d_rst_link", rf_link, 1'b0);
      chk("d_rst_pend", pend, 16'h0000);
    end

    step(); reset = 1'b1;
    @(negedge clk);
    chk("d_rr_first", {s2_ready, s1_ready, s0_ready}, 3'b001);
    step(); s0_valid = 1'b0;
    @(negedge clk);
    chk("d_rr_g1", {s2_ready, s1_ready, s0_ready}, 3'b010);
    chk("d_rr_wa3", {rf_wen, rf_wa}, {1'b1, 4'd3});
    chk("d_rr_din11", rf_din, 32'h11);
    step(); s1_valid = 1'b0;
    @(negedge clk);
    chk("d_rr_g2", {s2_ready, s1_ready, s0_ready}, 3'b100);
    chk("d_rr_wa4", {rf_wen, rf_wa, rf_din},
        {1'b1, 4'd4, 32'h22});
    step(); s2_valid = 1'b0;
    @(negedge clk);
    chk("d_rr_wa5", {rf_wen, rf_wa, rf_din},
        {1'b1, 4'd5, 32'h33});
    chk("d_rr_wrap", rr_ptr, 2'd0);
    step();
    @(negedge clk);
    chk("d_idle_wen", rf_wen, 1'b0);

    step();
    s1_valid = 1'b1; s1_wa = 4'd14; s1_din = 32'hAB;
    lnk_req  = 1'b1;
    @(negedge clk);
    chk("d_lnk_ready", {lnk_ready, s1_ready}, 2'b10);
    step(); lnk_req = 1'b0;
    @(negedge clk);
    chk("d_lnk_issue", {rf_link, rf_wen}, 2'b10);
    chk("d_lnk_s1", s1_ready, 1'b1);
    step(); s1_valid = 1'b0;
    @(negedge clk);
    chk("d_lnk_after", {rf_wen, rf_link, rf_wa},
        {1'b1, 1'b0, 4'd14});

    step();
    s2_valid = 1'b1; s2_wa = 4'd15; s2_din = 32'h100;
    @(negedge clk);
    step(); s2_valid = 1'b0;
    @(negedge clk);
    chk("d_pc_wr", {rf_wen, pc_wr, rf_din},
        {1'b1, 1'b1, 32'h100});
    step();
    s0_valid = 1'b1; s0_wa = 4'd7; s0_din = 32'h5;
    step(); s0_valid = 1'b0;
    @(negedge clk);
    chk("d_no_pc_wr", {rf_wen, pc_wr, rf_wa},
        {1'b1, 1'b0, 4'd7});

    step(); sb_set = 1'b1; sb_addr = 4'd6;
    step(); sb_set = 1'b0;
    s1_valid = 1'b1; s1_wa = 4'd6; s1_din = 32'h66;
    @(negedge clk);
    chk("d_sb_set", pend[6], 1'b1);
    step(); s1_valid = 1'b0;
    @(negedge clk);
    chk("d_sb_hold", {rf_wen, pend[6]}, 2'b11);
    step();
    @(negedge clk);
    chk("d_sb_clr", pend[6], 1'b0);

    step(); sb_set = 1'b1; sb_addr = 4'd6;
    step(); sb_set = 1'b0;
    s1_valid = 1'b1; s1_wa = 4'd6;
    step(); s1_valid = 1'b0; sb_set = 1'b1;
    @(negedge clk);
    chk("d_sb_wen6", {rf_wen, rf_wa}, {1'b1, 4'd6});
    step(); sb_set = 1'b0;
    @(negedge clk);
    chk("d_sb_setwins", pend[6], 1'b1);

    step();
    s0_valid = 1'b1; s0_wa = 4'd9; s0_din = 32'h99;
    reset = 1'b0;
    @(negedge clk);
    chk("d_mid_ready", s0_ready, 1'b0);
    step(); reset = 1'b1; s0_valid = 1'b0;
    @(negedge clk);
    chk("d_mid_out", {rf_wen, rf_link, pc_wr, rf_wa, rf_din},
        {3'b000, 4'd0, 32'h0});
    chk("d_mid_state", {pend, rr_ptr}, {16'h0, 2'd0});

    for (int c = 0; c < 3000; c++) begin
      step();
      if (!reset) reset = ($urandom_range(0, 1) == 0);
      else        reset = ($urandom_range(0, 299) != 0);
      lnk_req = !lnk_req && ($urandom_range(0, 9) == 0);
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_addr = rand_addr();
      if (!s0_valid || m_last[0]) new_req(s0_valid, s0_wa, s0_din);
      if (!s1_valid || m_last[1]) new_req(s1_valid, s1_wa, s1_din);
      if (!s2_valid || m_last[2]) new_req(s2_valid, s2_wa, s2_din);
    end

    step();
    reset = 1'b1; lnk_req = 1'b0; sb_set = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 16-entry register file among three write-back sources: ALU (source 0), memory load (source 1) and monitor/debug (source 2).
- Also schedules link (call) cycles. A link write to R14 overrides any normal write in the register file, so the two must never coincide.
- Keeps a pending-write scoreboard so the sequencer can stall on registers whose load has not yet returned.
- Sits between the execute/memory stages and the register file write inputs (wen, wa, din, link).

Parameters:
- WIDTH, 32, data width of write-back values.
- ADDR_SIZE, 4, register address width; register file holds 1<<ADDR_SIZE entries. The top entry is the PC and the entry below it is the link register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- s0_valid, s1_valid, s2_valid  input  1 each  source has a write pending.
- s0_ready, s1_ready, s2_ready  output  1 each  grant this cycle (combinational).
- s0_wa, s1_wa, s2_wa  input  ADDR_SIZE each  destination register.
- s0_din, s1_din, s2_din  input  WIDTH each  write data.
- lnk_req  input  1  request a link cycle (R14 <= PC+1).
- lnk_ready  output  1  link request accepted this cycle (combinational).
- sb_set  input  1  mark register sb_addr pending (load issued).
- sb_addr  input  ADDR_SIZE  register to mark.
- rf_wen  output  1  to register file wen.
- rf_wa  output  ADDR_SIZE  to register file wa.
- rf_din  output  WIDTH  to register file din.
- rf_link  output  1  to register file link.
- pc_wr  output  1  rf_wen with rf_wa == all-ones (PC overwrite). Sequencer uses it to flush.
- pend  output  1<<ADDR_SIZE  scoreboard bit per register.
- rr_ptr  output  2  current round-robin priority (0..2), for debug.

Behaviour:
- Reset (reset==0 at clk edge): rf_wen=0, rf_link=0, rf_wa=0, rf_din=0, pc_wr=0, pend=0, rr_ptr=0. All ready outputs are 0 while reset is low.
- Grant, cycle N (combinational):
  - If lnk_req=1: lnk_ready=1 and all sX_ready=0.
  - Otherwise the first valid source in rotating order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) gets ready=1. At most one ready is high.
- Transfer occurs when valid and ready are both 1. A source must hold valid, wa and din stable until ready.
- Issue, cycle N+1 (registered outputs):
  - After a data transfer: rf_wen=1, rf_wa and rf_din are the captured values, rf_link=0.
  - After a link transfer: rf_link=1, rf_wen=0.
  - With no transfer: rf_wen=0 and rf_link=0, and rf_wa/rf_din hold their previous values.
  - rf_wen and rf_link are never both 1. Fixed one-cycle latency, one write per cycle, no internal queueing.
- Round-robin update: after a data grant to source k, rr_ptr <= (k+1) mod 3. It is unchanged on link or idle cycles. Wrap from 2 goes to 0.
- pc_wr = rf_wen & (rf_wa == all-ones), registered alongside rf_wen.
- Scoreboard, per register r, evaluated at each clock edge:
  - Set if sb_set and sb_addr==r.
  - Otherwise cleared if a data transfer with wa==r occurred in the previous cycle, i.e. rf_wen is currently 1 with rf_wa==r.
  - Set beats clear on the same register in the same cycle.
  - A link cycle clears pend[R14].
  - pend is a direct register output.
- Starvation bound: with all three sources continuously valid and no link, each source is granted at least once every 3 cycles. Link requests may starve data sources; the sequencer keeps lnk_req to single-cycle pulses.
- Reset mid-operation: any granted-but-not-issued write is dropped. rf_wen is 0 in the cycle after reset is sampled low.

Test Plan:
- Reset held low 2 cycles with all sources valid -> all ready=0, rf_wen=0, rf_link=0, pend=0. After release, s0 is granted first (rr_ptr=0).
- s0 (wa=3, din=0x11), s1 (wa=4, din=0x22) and s2 (wa=5, din=0x33) all held valid -> grants in cycles 1, 2, 3 go to s0, s1, s2. rf_wen is high in cycles 2–4 with wa 3, 4, 5 and matching data. rr_ptr returns to 0.
- lnk_req pulse while s1 is valid with wa=14 -> cycle N: lnk_ready=1, s1_ready=0. Cycle N+1: rf_link=1, rf_wen=0. Cycle N+1: s1 is granted. Cycle N+2: rf_wen=1 with wa=14 (the data write lands after the link).
- s2 writes wa=15, din=0x100 -> one cycle later rf_wen=1 and pc_wr=1. A write to wa=7 gives pc_wr=0.
- sb_set with sb_addr=6 -> pend[6]=1. Then s1 writes wa=6 -> pend[6] clears one cycle after rf_wen. With sb_set on 6 in the same cycle as the clear, pend[6] stays 1.
- Reset asserted in the cycle s0 is granted (wa=9) -> no rf_wen for wa=9 afterwards, and outputs show reset values.
